nash_byte_serializer: RTL and testbench
=======================================

# nash_byte_serializer

Byte-to-bit front end for the Nash stream cipher core. It accepts plaintext/ciphertext bytes over a valid/ready interface and buffers them in a small FIFO. It emits one bit per cycle on a `data_in`/`valid_in`-style stream that drives the cipher core directly. A `hold` input pauses the bit stream without losing position, so the core can be reconfigured. A `flush` input discards everything queued or in flight.

## Interface
- `BYTE_W`, 8, bits per input word
- `FIFO_DEPTH`, 4, byte FIFO entries (power of two, ≥2)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `s_data`  in  BYTE_W  input byte
- `s_valid`  in  1  input byte valid
- `s_ready`  out  1  FIFO can accept; equals `fifo_level != FIFO_DEPTH` and `!flush`
- `hold`  in  1  pause bit emission (tie to core `config_valid` / config busy)
- `flush`  in  1  synchronous discard of FIFO and shifter
- `bit_out`  out  1  serial bit, connects to core `data_in`
- `bit_valid`  out  1  bit valid, connects to core `valid_in`
- `byte_start`  out  1  high with the first bit of each byte
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte in the shifter
- `busy`  out  1  shifter active or `fifo_level != 0`

## Operation
- Handshake: a byte is accepted on a rising edge where `s_valid && s_ready`. `s_ready` has no full-bypass: when the FIFO is full it is low even if a pop occurs in the same cycle.
- Shifter FSM states:
  - `IDLE`: shift reg is 0, `bit_valid` = 0.
  - `SHIFT`: byte loaded, `bit_cnt` 0..BYTE_W-1.
- `IDLE` → `SHIFT`: on an edge with FIFO non-empty and `!hold`. Pops the FIFO head into the shift reg, `bit_cnt` = 0.
- `bit_valid = (state == SHIFT) && !hold` (combinational from regs + `hold`).
- `bit_out` = next bit of the shift reg. `byte_start = bit_valid && bit_cnt == 0`.
- On each edge with `bit_valid`, `bit_cnt` increments and the shift reg advances.
- On the edge consuming bit BYTE_W-1:
  - If the FIFO is non-empty, the next byte is popped and loaded (stay in `SHIFT`, `bit_cnt` = 0, no bubble).
  - Otherwise go to `IDLE`.
- `hold` high: no shift, no pop, `bit_cnt` frozen. This applies in both states, including on the final bit. Pushes still accepted.
- `flush` high (priority over push, pop, hold):
  - On the edge: FIFO emptied, `fifo_level` = 0, state `IDLE`, shift reg and `bit_cnt` cleared.
  - During the flush cycle: `s_ready` = 0 and no byte is accepted.
- Push and pop on the same edge: `fifo_level` unchanged.
- Reset values:
  - `bit_out` 0, `bit_valid` 0, `byte_start` 0
  - `fifo_level` 0, `busy` 0, `s_ready` 1
  - state `IDLE`
- Reset mid-byte discards all data, with no partial output.

## Timing
- Latency: byte accepted on the edge ending cycle N, FIFO empty, shifter idle. It is popped on the edge ending N+1, and its bits are valid in cycles N+2..N+BYTE_W+1 with no `hold`.
- Sustained throughput: 1 byte / BYTE_W cycles while the FIFO is non-empty. Bits of consecutive bytes are contiguous.
- `hold` takes effect combinationally: a bit shown while `hold` = 1 is not valid and is re-presented once `hold` falls.
- `s_ready` depends only on registers and `flush`, with no path from `s_valid`.

## Configuration
- `NASH_SER_LSB_FIRST_EN`
  - Defined: bit 0 of each byte is emitted first (shift right).
  - Undefined (default): MSB first (bit BYTE_W-1 first, shift left).
- The macro changes only bit order; latency, handshake and `byte_start` are identical.

## Structure
- `nash_pkg`: holds the shifter state enum (`SER_IDLE`, `SER_SHIFT`) and the `NASH_BYTE_W` constant used as the `BYTE_W` default.
- Sub-module `nash_sync_fifo`:
  - Parameterised width/depth, async active-low reset, synchronous clear.
  - Signals: push/pop/full/empty/level.
  - Reusable for the output byte packer downstream of the core.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream → `bit_valid` = 0, `s_ready` = 1, `fifo_level` = 0, `busy` = 0 immediately. After release, no stale bits appear.
- Single byte 0xA5, accepted at edge N (MSB-first) → bits 1,0,1,0,0,1,0,1 with `bit_valid` high in cycles N+2..N+9, `byte_start` only in N+2. With `NASH_SER_LSB_FIRST_EN` → 1,0,1,0,0,1,0,1 (palindrome); also check 0x01 → 1 then seven 0s.
- Back-to-back 0x3C, 0xFF, 0x00 pushed on consecutive edges → 24 consecutive `bit_valid` cycles with no gap, and three `byte_start` pulses spaced 8 cycles apart.
- Fill under `hold` = 1: offer 6 bytes → 4 accepted, `s_ready` low, `fifo_level` = 4, `bit_valid` 0. Release hold → 32 contiguous bits, and `s_ready` rises on the first pop.
- Hold mid-byte: assert `hold` after bit 2 of 0xC3 for 5 cycles → `bit_valid` low for 5 cycles, then bits 3..7 resume. Exactly 8 valid bits total, matching 0xC3.
- Flush mid-byte with `fifo_level` = 2 and `s_valid` high → `s_ready` 0 in the flush cycle. Next cycle: `bit_valid` 0, `fifo_level` 0, `busy` 0. The offered byte is dropped.

Source files
------------

// File: rtl/nash_pkg.sv
// Shared types and constants for the Nash cipher front end.
package nash_pkg;

    localparam int NASH_BYTE_W = 8;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/nash_sync_fifo.sv
// Synchronous FIFO with level output, synchronous clear and async active-low reset.
module nash_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_d = level_q + 1'b1;
            else if (!do_push && do_pop) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; validity is tracked entirely by level_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/nash_byte_serializer.sv
// Byte-to-bit front end for the Nash cipher core: byte FIFO plus one-bit-per-cycle shifter.
// Define NASH_SER_LSB_FIRST_EN to emit bit 0 first; default is MSB first.
module nash_byte_serializer
    import nash_pkg::*;
#(
    parameter int BYTE_W     = NASH_BYTE_W,
    parameter int FIFO_DEPTH = 4,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              hold,
    input  logic              flush,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              byte_start,
    output logic [LW-1:0]     fifo_level,
    output logic              busy
);

    localparam int CW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(BYTE_W - 1);

    ser_state_e        state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shreg_adv;
    logic [BYTE_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic              push, pop;

    // No full-bypass: s_ready must not depend on this cycle's pop.
    assign s_ready = !fifo_full && !flush;
    assign push    = s_valid && s_ready;

    nash_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef NASH_SER_LSB_FIRST_EN
    assign bit_out   = shreg_q[0];
    assign shreg_adv = {1'b0, shreg_q[BYTE_W-1:1]};
`else
    assign bit_out   = shreg_q[BYTE_W-1];
    assign shreg_adv = {shreg_q[BYTE_W-2:0], 1'b0};
`endif

    assign bit_valid  = (state_q == SER_SHIFT) && !hold;
    assign byte_start = bit_valid && (bit_cnt_q == '0);
    assign busy       = (state_q == SER_SHIFT) || !fifo_empty;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;
        if (flush) begin
            state_d   = SER_IDLE;
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (!hold) begin
            case (state_q)
                SER_IDLE: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_d   = SER_SHIFT;
                        shreg_d   = fifo_rdata;
                        bit_cnt_d = '0;
                    end
                end
                SER_SHIFT: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        // Reload straight from the FIFO so consecutive bytes have no bubble.
                        bit_cnt_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = fifo_rdata;
                        end else begin
                            state_d = SER_IDLE;
                            shreg_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = shreg_adv;
                    end
                end
                default: begin
                    state_d   = SER_IDLE;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SER_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_nash_byte_serializer.sv
// Self-checking bench for nash_byte_serializer against a queue-based bit-stream model.
module tb_nash_byte_serializer;

    localparam int BW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] s_data;
    logic          s_valid, s_ready, hold, flush;
    logic          bit_out, bit_valid, byte_start, busy;
    logic [2:0]    fifo_level;

    nash_byte_serializer #(.BYTE_W(BW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .hold       (hold),
        .flush      (flush),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .byte_start (byte_start),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: accepted bytes waiting, and remaining bits of the byte on the wire.
    logic [BW-1:0] byte_q [$];
    bit            cur_bits [$];
    int            cyc;
    int            last_start_cyc;
    int            n_obs_bits;
    logic [BW-1:0] obs_byte;

    function automatic void load_byte(input logic [BW-1:0] b);
        cur_bits.delete();
        for (int i = 0; i < BW; i++) begin
`ifdef NASH_SER_LSB_FIRST_EN
            cur_bits.push_back(b[i]);
`else
            cur_bits.push_back(b[BW-1-i]);
`endif
        end
    endfunction

    // One clock cycle: drive inputs, compare all outputs, advance the model across the edge.
    task automatic step(input logic v, input logic [BW-1:0] d, input logic h, input logic f);
        logic exp_valid, exp_ready, acc;
        @(negedge clk);
        s_valid = v; s_data = d; hold = h; flush = f;
        #1;
        exp_valid = (cur_bits.size() != 0) && !h;
        exp_ready = (byte_q.size() != DEPTH) && !f;
        chk("bit_valid", 32'(bit_valid), 32'(exp_valid));
        chk("byte_start", 32'(byte_start), 32'(exp_valid && cur_bits.size() == BW));
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("fifo_level", 32'(fifo_level), 32'(byte_q.size()));
        chk("busy", 32'(busy), 32'(cur_bits.size() != 0 || byte_q.size() != 0));
        chk("bit_out", 32'(bit_out), 32'((cur_bits.size() != 0) ? cur_bits[0] : 1'b0));
        if (byte_start) last_start_cyc = cyc;
        if (bit_valid) begin
`ifdef NASH_SER_LSB_FIRST_EN
            obs_byte = {bit_out, obs_byte[BW-1:1]};
`else
            obs_byte = {obs_byte[BW-2:0], bit_out};
`endif
            n_obs_bits++;
        end
        if (f) begin
            byte_q.delete();
            cur_bits.delete();
        end else begin
            acc = v && exp_ready;
            if (exp_valid) void'(cur_bits.pop_front());
            if (!h && cur_bits.size() == 0 && byte_q.size() != 0) load_byte(byte_q.pop_front());
            if (acc) byte_q.push_back(d);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    int            acc_cyc;
    logic [BW-1:0] rb;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; hold = 1'b0; flush = 1'b0;
        cyc = 0; last_start_cyc = -1; n_obs_bits = 0; obs_byte = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        idle(2);

        // Single byte latency and content.
        acc_cyc = cyc;
        n_obs_bits = 0;
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(12);
        chk("a5_start_latency", 32'(last_start_cyc - acc_cyc), 32'd2);
        chk("a5_bits", 32'(obs_byte), 32'hA5);
        chk("a5_nbits", 32'(n_obs_bits), 32'd8);

        n_obs_bits = 0;
        step(1'b1, 8'h01, 1'b0, 1'b0);
        idle(12);
        chk("x01_bits", 32'(obs_byte), 32'h01);

        // Back-to-back bytes.
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        idle(30);

        // Fill under hold, then release.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
        chk("fill_level", 32'(fifo_level), 32'd4);
        idle(40);

        // Hold mid-byte.
        n_obs_bits = 0;
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        idle(4);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle(8);
        chk("c3_bits", 32'(obs_byte), 32'hC3);
        chk("c3_nbits", 32'(n_obs_bits), 32'd8);

        // Flush mid-byte with two queued and a byte on offer.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h69, 1'b0, 1'b0);
        step(1'b1, 8'h96, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        idle(12);

        // Reset mid-stream.
        step(1'b1, 8'hB7, 1'b0, 1'b0);
        step(1'b1, 8'h4D, 1'b0, 1'b0);
        idle(4);
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; hold = 1'b0; flush = 1'b0;
        #1;
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bit_out", 32'(bit_out), 32'd0);
        byte_q.delete();
        cur_bits.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // Randomized phases with varying push/hold/flush density.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 1500; i++) begin
                rb = 8'($urandom);
                step(($urandom_range(99) < 30 + 20 * p),
                     rb,
                     ($urandom_range(99) < (p == 2 ? 30 : 8)),
                     ($urandom_range(999) < (p == 3 ? 20 : 3)));
            end
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
